// File: rtl/intercal_pkg.sv
// Shared types and constants for the INTERCAL ALU byte sequencer.
package intercal_pkg;

    localparam int OPCODE_W      = 4;
    localparam int CMD_UNARY_BIT = 4;
    localparam int WORD_BYTES    = 4;

    // Byte counter value that marks the final (MSB) byte of a word.
    localparam logic [1:0] LAST_BYTE = 2'(WORD_BYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_EXEC   = 3'd3,
        ST_SEND   = 3'd4
    } state_t;

endpackage

// File: rtl/intercal_alu_seq.sv
// Byte-serial front end for an external combinational INTERCAL ALU:
// takes a command byte plus LSB-first operand bytes, captures the ALU
// result for one cycle, then streams it back LSB-first.
module intercal_alu_seq
    import intercal_pkg::*;
#(
    parameter bit UNARY_CLEARS_B = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [7:0]          in_data,
    output logic [OPCODE_W-1:0] alu_op,
    output logic [31:0]         alu_a,
    output logic [31:0]         alu_b,
    input  logic [31:0]         alu_f,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [7:0]          out_data,
    output logic                out_last
);

    state_t      state;
    logic [1:0]  cnt;       // byte index within the word being loaded or sent
    logic        unary_q;
    logic [31:0] result_q;
    logic        run_q;     // holds in_ready low until the first edge after reset

    logic in_fire;
    logic out_fire;

    // Handshakes and stream outputs decode directly from registered state.
    assign in_ready  = run_q && (state == ST_IDLE || state == ST_LOAD_A || state == ST_LOAD_B);
    assign out_valid = (state == ST_SEND);
    assign out_data  = out_valid ? result_q[{cnt, 3'b000} +: 8] : 8'h00;
    assign out_last  = out_valid && (cnt == LAST_BYTE);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    // Sequencer FSM: command, operand A, optional operand B, execute, send.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= 2'd0;
            unary_q  <= 1'b0;
            result_q <= '0;
            alu_op   <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            run_q    <= 1'b0;
        end else begin
            run_q <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (in_fire) begin
                        alu_op  <= in_data[OPCODE_W-1:0];
                        unary_q <= in_data[CMD_UNARY_BIT];
                        if (in_data[CMD_UNARY_BIT] && UNARY_CLEARS_B)
                            alu_b <= '0;
                        cnt   <= 2'd0;
                        state <= ST_LOAD_A;
                    end
                end
                ST_LOAD_A: begin
                    if (in_fire) begin
                        alu_a[{cnt, 3'b000} +: 8] <= in_data;
                        cnt <= cnt + 2'd1;
                        if (cnt == LAST_BYTE)
                            state <= unary_q ? ST_EXEC : ST_LOAD_B;
                    end
                end
                ST_LOAD_B: begin
                    if (in_fire) begin
                        alu_b[{cnt, 3'b000} +: 8] <= in_data;
                        cnt <= cnt + 2'd1;
                        if (cnt == LAST_BYTE)
                            state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // Operands are stable registers here, so alu_f has settled.
                    result_q <= alu_f;
                    cnt      <= 2'd0;
                    state    <= ST_SEND;
                end
                ST_SEND: begin
                    if (out_fire) begin
                        cnt <= cnt + 2'd1;
                        if (cnt == LAST_BYTE)
                            state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_intercal_alu_seq.sv
// Directed bench for intercal_alu_seq with an XOR stand-in for the ALU.
module tb_intercal_alu_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'h00;
    logic [3:0]  alu_op;
    logic [31:0] alu_a, alu_b, alu_f;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_data;
    logic        out_last;

    // Second instance with UNARY_CLEARS_B=0, driven by the same stream.
    logic        in_ready2, out_valid2, out_last2;
    logic [3:0]  alu_op2;
    logic [31:0] alu_a2, alu_b2, alu_f2;
    logic [7:0]  out_data2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign alu_f  = alu_a ^ alu_b;
    assign alu_f2 = alu_a2 ^ alu_b2;

    intercal_alu_seq #(.UNARY_CLEARS_B(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
    );

    intercal_alu_seq #(.UNARY_CLEARS_B(1'b0)) dut_keep_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .alu_op(alu_op2), .alu_a(alu_a2), .alu_b(alu_b2), .alu_f(alu_f2),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .out_last(out_last2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte transfers.
    task automatic send_byte(input logic [7:0] b, input int gap, output int waited);
        in_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            check("ready_during_gap", 32'(in_ready), 32'd1);
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        waited   = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) check("in_ready_timeout", 32'(waited), 32'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h5A;
    endtask

    task automatic send_txn(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] b,
                            input bit unary, input bit gaps, output int cmd_wait);
        int w;
        send_byte(cmd, gaps ? int'($urandom_range(0, 3)) : 0, cmd_wait);
        for (int i = 0; i < 4; i++)
            send_byte(a[i*8 +: 8], gaps ? int'($urandom_range(0, 3)) : 0, w);
        if (!unary)
            for (int i = 0; i < 4; i++)
                send_byte(b[i*8 +: 8], gaps ? int'($urandom_range(0, 3)) : 0, w);
    endtask

    // Fixed latency: at the negedge after the last operand edge we are in
    // EXEC (nothing valid, not ready); one cycle later the first byte shows.
    task automatic check_latency();
        check("exec_out_valid", 32'(out_valid), 32'd0);
        check("exec_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("send_out_valid", 32'(out_valid), 32'd1);
    endtask

    task automatic recv_word(input logic [31:0] exp, input int stall_at, input int stall_len);
        int w;
        for (int i = 0; i < 4; i++) begin
            w = 0;
            while (!out_valid && w < 20) begin
                @(negedge clk);
                w++;
            end
            if (w >= 20) check("out_valid_timeout", 32'(w), 32'd0);
            check("send_in_ready", 32'(in_ready), 32'd0);
            if (i == stall_at) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    check("stall_out_valid", 32'(out_valid), 32'd1);
                    check("stall_out_data", 32'(out_data), 32'(exp[i*8 +: 8]));
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
            check($sformatf("out_byte%0d", i), 32'(out_data), 32'(exp[i*8 +: 8]));
            check($sformatf("out_last%0d", i), 32'(out_last), 32'(i == 3));
            @(posedge clk);
            @(negedge clk);
        end
        check("idle_out_valid", 32'(out_valid), 32'd0);
        check("idle_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int w;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        rst = 1'b0;
        check("pre_edge_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("post_edge_in_ready", 32'(in_ready), 32'd1);

        // Binary op: 0x12345678 ^ 0x9ABCDEF0 = 0x88888888
        send_txn(8'h02, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, w);
        check("bin_alu_op", 32'(alu_op), 32'd2);
        check("bin_alu_a", alu_a, 32'h12345678);
        check("bin_alu_b", alu_b, 32'h9ABCDEF0);
        check_latency();
        recv_word(32'h88888888, -1, 0);

        // Unary op: B cleared in the default instance, kept in the other
        send_txn(8'h11, 32'h00FF00FF, 32'h0, 1'b1, 1'b0, w);
        check_latency();
        check("un_alu_op", 32'(alu_op), 32'd1);
        check("un_alu_b", alu_b, 32'h0);
        check("un_keep_alu_b", alu_b2, 32'h9ABCDEF0);
        recv_word(32'h00FF00FF, -1, 0);

        // Backpressure on byte 2
        send_txn(8'h02, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, w);
        check_latency();
        recv_word(32'h88888888, 2, 5);

        // Input gaps; upper command bits ignored (0xE5 -> op 5, binary)
        send_txn(8'hE5, 32'h11223344, 32'h0F0F0F0F, 1'b0, 1'b1, w);
        check("gap_alu_op", 32'(alu_op), 32'd5);
        check_latency();
        recv_word(32'h1E2D3C4B, -1, 0);

        // Reset after the 2nd B byte
        send_byte(8'h02, 0, w);
        for (int i = 0; i < 4; i++) send_byte(8'hA0 + 8'(i), 0, w);
        send_byte(8'hB0, 0, w);
        send_byte(8'hB1, 0, w);
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_data", 32'(out_data), 32'd0);
        check("mid_rst_alu_a", alu_a, 32'd0);
        check("mid_rst_alu_b", alu_b, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("rel_in_ready_pre", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("rel_in_ready_post", 32'(in_ready), 32'd1);
        check("rel_out_valid", 32'(out_valid), 32'd0);
        // 0xDEADBEEF ^ 0x12345678 = 0xCC99E897
        send_txn(8'h07, 32'hDEADBEEF, 32'h12345678, 1'b0, 1'b0, w);
        check_latency();
        recv_word(32'hCC99E897, -1, 0);

        // Back-to-back: next command offered the cycle after out_last
        send_txn(8'h10, 32'h01020304, 32'h0, 1'b1, 1'b0, w);
        check("b2b_cmd_wait", 32'(w), 32'd0);
        check_latency();
        recv_word(32'h01020304, -1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
